// File: rtl/xyolo_wr_pack.sv
// xyolo_wr_pack: packs a stream of signed result samples into wide memory
// words and issues them as write requests.
//
// Each accepted sample is saturated to signed OUT_W and dropped into the next
// lane of an accumulating word. A full word (or the final partial word of a
// job) moves into a single-entry output register that drives the memory write
// port with its byte strobes. Write addresses start at base_addr and wrap.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   run                   start pulse (ignored unless idle)
//   base_addr, n_samples  job parameters, captured on an accepted run
//   in_valid/in_data      sample input, in_ready = sample taken this cycle
//   m_valid/m_ready       write request handshake
//   m_addr/m_wdata/m_wstrb  write address, packed data, byte enables
//   busy                  job in progress (RUN or FLUSH)
//   done                  one-cycle completion pulse
module xyolo_wr_pack #(
  parameter int DATAPATH_W = 32,
  parameter int OUT_W      = 16,
  parameter int MEM_W      = 256,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           n_samples,
  input  logic                  in_valid,
  input  logic [DATAPATH_W-1:0] in_data,
  output logic                  in_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [MEM_W-1:0]      m_wdata,
  output logic [MEM_W/8-1:0]    m_wstrb,
  output logic                  busy,
  output logic                  done
);

  localparam int PACK   = MEM_W / OUT_W;
  localparam int LANE_W = $clog2(PACK);
  localparam int LANE_B = OUT_W / 8;

  localparam logic signed [DATAPATH_W-1:0] SAT_MAX =
    DATAPATH_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [DATAPATH_W-1:0] SAT_MIN =
    DATAPATH_W'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t              state_reg;
  logic [LANE_W-1:0]   lane_cnt_reg;
  logic [15:0]         sample_cnt_reg;
  logic [15:0]         n_reg;
  logic [MEM_W-1:0]    pack_reg;
  logic                m_valid_reg;
  logic [ADDR_W-1:0]   m_addr_reg;
  logic [MEM_W-1:0]    m_wdata_reg;
  logic [MEM_W/8-1:0]  m_wstrb_reg;
  logic                busy_reg;
  logic                done_reg;

  logic                        in_ready_int;
  logic                        accept;
  logic                        last_sample;
  logic                        load_word;
  logic signed [DATAPATH_W-1:0] in_s;
  logic [OUT_W-1:0]            sat_val;
  logic [MEM_W-1:0]            lane_word;
  logic [MEM_W/8-1:0]          lane_strb;

  // The output register can take a new word when it is empty or being
  // drained in this very cycle.
  assign in_ready_int = (state_reg == ST_RUN) && (!m_valid_reg || m_ready);
  assign accept       = in_valid && in_ready_int;
  assign last_sample  = (sample_cnt_reg == n_reg - 16'd1);
  assign load_word    = (lane_cnt_reg == LANE_W'(PACK - 1)) || last_sample;

  assign in_s = in_data;

  always_comb begin
    sat_val = in_data[OUT_W-1:0];
    if (in_s > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (in_s < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end
  end

  // Word as it looks with the current sample inserted; strobes cover every
  // lane up to and including the current one, so a partial word only enables
  // the filled lanes (unfilled lanes stay zero in pack_reg).
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      assign lane_word[gi*OUT_W +: OUT_W] =
        (lane_cnt_reg == LANE_W'(gi)) ? sat_val : pack_reg[gi*OUT_W +: OUT_W];
      assign lane_strb[gi*LANE_B +: LANE_B] =
        {LANE_B{lane_cnt_reg >= LANE_W'(gi)}};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      lane_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
      n_reg          <= '0;
      pack_reg       <= '0;
      m_valid_reg    <= 1'b0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
      m_wstrb_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      // Drain: free the register and advance to the next word address.
      if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
        m_addr_reg  <= m_addr_reg + ADDR_W'(1);
      end

      // Fill: a load in the draining cycle overrides the clear above.
      if (accept) begin
        sample_cnt_reg <= sample_cnt_reg + 16'd1;
        if (load_word) begin
          m_valid_reg  <= 1'b1;
          m_wdata_reg  <= lane_word;
          m_wstrb_reg  <= lane_strb;
          pack_reg     <= '0;
          lane_cnt_reg <= '0;
        end else begin
          pack_reg     <= lane_word;
          lane_cnt_reg <= lane_cnt_reg + LANE_W'(1);
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            m_addr_reg     <= base_addr;
            n_reg          <= n_samples;
            sample_cnt_reg <= '0;
            lane_cnt_reg   <= '0;
            pack_reg       <= '0;
            if (n_samples == 16'd0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept && last_sample) begin
            state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!m_valid_reg) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_int;
  assign m_valid  = m_valid_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign m_wstrb  = m_wstrb_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_xyolo_wr_pack.sv
// Testbench for xyolo_wr_pack: randomized jobs checked against a word-level
// reference model computed directly from the sample list.
module tb_xyolo_wr_pack;

  localparam int DW   = 32;
  localparam int OW   = 16;
  localparam int MW   = 256;
  localparam int AW   = 12;
  localparam int PACK = MW / OW;
  localparam int SB   = MW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [AW-1:0] base_addr;
  logic [15:0]   n_samples;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [MW-1:0] m_wdata;
  logic [SB-1:0] m_wstrb;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  xyolo_wr_pack #(
    .DATAPATH_W(DW), .OUT_W(OW), .MEM_W(MW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .base_addr(base_addr), .n_samples(n_samples),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .busy(busy), .done(done)
  );

  int checks   = 0;
  int failures = 0;

  // Monitor: sole writer of the observation log, sampled on the falling edge.
  int            cyc_cnt  = 0;
  int            wr_cnt   = 0;
  int            acc_cnt  = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  logic [AW-1:0] wr_addr [0:255];
  logic [MW-1:0] wr_data [0:255];
  logic [SB-1:0] wr_strb [0:255];
  int            wr_cyc  [0:255];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready && wr_cnt < 256) begin
      wr_addr[wr_cnt] <= m_addr;
      wr_data[wr_cnt] <= m_wdata;
      wr_strb[wr_cnt] <= m_wstrb;
      wr_cyc[wr_cnt]  <= cyc_cnt;
      wr_cnt          <= wr_cnt + 1;
    end
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_cnt;
    end
  end

  // Stimulus samples and expected writes.
  logic [DW-1:0] stim     [0:1023];
  logic [AW-1:0] exp_addr [0:127];
  logic [MW-1:0] exp_data [0:127];
  logic [SB-1:0] exp_strb [0:127];
  int            exp_n;

  // Reference model: word w holds samples w*PACK .. w*PACK+PACK-1, each
  // clamped to the signed 16-bit range; strobes cover only present samples.
  task automatic build_model(input logic [AW-1:0] base, input int n);
    exp_n = (n + PACK - 1) / PACK;
    for (int w = 0; w < exp_n; w++) begin
      logic [MW-1:0] word;
      logic [SB-1:0] strb;
      int present;
      word = '0;
      strb = '0;
      present = (n - w * PACK < PACK) ? n - w * PACK : PACK;
      for (int k = 0; k < present; k++) begin
        int v;
        v = int'($signed(stim[w * PACK + k]));
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        word[k * OW +: OW] = OW'(v);
      end
      for (int b = 0; b < present * (OW / 8); b++) strb[b] = 1'b1;
      exp_addr[w] = AW'(int'(base) + w);
      exp_data[w] = word;
      exp_strb[w] = strb;
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(2))
        0: stim[i] = $urandom;
        1: stim[i] = DW'($urandom_range(65535)) - 32'd32768;
        default: stim[i] = DW'($urandom_range(65539)) - 32'd32770;
      endcase
    end
  endtask

  // Drives one job; call and return at posedge+1. busy_run_at >= 0 pulses a
  // spurious run with different parameters at that loop cycle.
  task automatic run_job(input logic [AW-1:0] base, input int n, input int vprob,
                         input int rprob, input int busy_run_at, input int budget,
                         output bit to);
    int  idx;
    int  cyc;
    int  d0;
    bit  take;
    idx = 0;
    cyc = 0;
    d0  = done_cnt;
    base_addr = base;
    n_samples = 16'(n);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    while (done_cnt == d0 && cyc < budget) begin
      run = (cyc == busy_run_at);
      if (run) begin
        base_addr = 12'h555;
        n_samples = 16'd5;
      end
      in_valid = (idx < n) && ($urandom_range(99) < vprob);
      in_data  = stim[idx < 1024 ? idx : 0];
      m_ready  = ($urandom_range(99) < rprob);
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    run      = 1'b0;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    to = (done_cnt == d0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (m_wdata !== '0 || m_wstrb !== '0) begin failures++; $display("FAIL reset_wdata_wstrb: got %h %h want 0", m_wdata, m_wstrb); end
    checks++; if (m_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h want 000", m_addr); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL reset_idle_after: got busy=%b in_ready=%b want 0 0", busy, in_ready); end
  endtask

  task automatic test_full_stream;
    int wb; int ab; int db; bit to;
    for (int i = 0; i < 32; i++) stim[i] = DW'(i);
    build_model(12'h010, 32);
    wb = wr_cnt; ab = acc_cnt; db = done_cnt;
    run_job(12'h010, 32, 100, 100, -1, 500, to);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (to) begin failures++; $display("FAIL full_timeout: no done within budget"); end
    checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL full_count: got %0d writes want 2", wr_cnt - wb); end
    for (int i = 0; i < exp_n && i < wr_cnt - wb; i++) begin
      checks++;
      if (wr_addr[wb+i] !== exp_addr[i] || wr_data[wb+i] !== exp_data[i] || wr_strb[wb+i] !== exp_strb[i]) begin
        failures++;
        $display("FAIL full_word%0d: got addr=%h strb=%h data=%h want addr=%h strb=%h data=%h",
                 i, wr_addr[wb+i], wr_strb[wb+i], wr_data[wb+i], exp_addr[i], exp_strb[i], exp_data[i]);
      end
    end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("FAIL full_done_count: got %0d want 1", done_cnt - db); end
    if (wr_cnt - wb == 2) begin
      checks++; if (done_cyc <= wr_cyc[wb+1]) begin failures++; $display("FAIL full_done_order: done cycle %0d write cycle %0d want done later", done_cyc, wr_cyc[wb+1]); end
    end
    checks++; if (acc_cnt - ab !== 32) begin failures++; $display("FAIL full_accepted: got %0d want 32", acc_cnt - ab); end
  endtask

  task automatic test_saturation;
    int wb; bit to;
    logic [OW-1:0] want [0:3];
    want[0] = 16'h7FFF; want[1] = 16'h8000; want[2] = 16'h7FFF; want[3] = 16'h8000;
    fill_random(16);
    stim[0] = 32'h00012345; stim[1] = 32'hFFFF0000; stim[2] = 32'h00007FFF; stim[3] = 32'hFFFF8000;
    build_model(12'h123, 16);
    wb = wr_cnt;
    run_job(12'h123, 16, 80, 80, -1, 500, to);
    checks++; if (to) begin failures++; $display("FAIL sat_timeout: no done within budget"); end
    checks++; if (wr_cnt - wb !== 1) begin failures++; $display("FAIL sat_count: got %0d want 1", wr_cnt - wb); end
    if (wr_cnt - wb >= 1) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_data[wb][k*OW +: OW] !== want[k]) begin failures++; $display("FAIL sat_lane%0d: got %h want %h", k, wr_data[wb][k*OW +: OW], want[k]); end
      end
      checks++;
      if (wr_data[wb] !== exp_data[0] || wr_strb[wb] !== exp_strb[0] || wr_addr[wb] !== exp_addr[0]) begin
        failures++; $display("FAIL sat_word: got %h want %h", wr_data[wb], exp_data[0]);
      end
    end
  endtask

  task automatic test_partial;
    int wb; bit to;
    fill_random(20);
    build_model(12'h040, 20);
    wb = wr_cnt;
    run_job(12'h040, 20, 75, 75, -1, 500, to);
    checks++; if (to) begin failures++; $display("FAIL partial_timeout: no done within budget"); end
    checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL partial_count: got %0d want 2", wr_cnt - wb); end
    if (wr_cnt - wb >= 2) begin
      checks++; if (wr_strb[wb+1] !== 32'h000000FF) begin failures++; $display("FAIL partial_strb: got %h want 000000ff", wr_strb[wb+1]); end
      checks++; if (wr_data[wb+1][MW-1:64] !== '0) begin failures++; $display("FAIL partial_zero_lanes: got %h want 0", wr_data[wb+1][MW-1:64]); end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr[wb+i] !== exp_addr[i] || wr_data[wb+i] !== exp_data[i] || wr_strb[wb+i] !== exp_strb[i]) begin
          failures++;
          $display("FAIL partial_word%0d: got addr=%h data=%h want addr=%h data=%h", i, wr_addr[wb+i], wr_data[wb+i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_random_jobs;
    for (int j = 0; j < 6; j++) begin
      int wb; int n; bit to; logic [AW-1:0] base;
      n    = $urandom_range(70, 1);
      base = AW'($urandom);
      fill_random(n);
      build_model(base, n);
      wb = wr_cnt;
      run_job(base, n, 70, 60, -1, 3000, to);
      checks++; if (to) begin failures++; $display("FAIL rand%0d_timeout: no done within budget", j); end
      checks++; if (wr_cnt - wb !== exp_n) begin failures++; $display("FAIL rand%0d_count: got %0d want %0d", j, wr_cnt - wb, exp_n); end
      for (int i = 0; i < exp_n && i < wr_cnt - wb; i++) begin
        checks++;
        if (wr_addr[wb+i] !== exp_addr[i] || wr_data[wb+i] !== exp_data[i] || wr_strb[wb+i] !== exp_strb[i]) begin
          failures++;
          $display("FAIL rand%0d_word%0d: got addr=%h strb=%h data=%h want addr=%h strb=%h data=%h",
                   j, i, wr_addr[wb+i], wr_strb[wb+i], wr_data[wb+i], exp_addr[i], exp_strb[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int wb; int ab; int idx; int cyc; bit take;
    logic [AW-1:0] cap_addr; logic [MW-1:0] cap_data; logic [SB-1:0] cap_strb;
    fill_random(32);
    build_model(12'h100, 32);
    wb = wr_cnt; ab = acc_cnt; idx = 0; cyc = 0;
    base_addr = 12'h100; n_samples = 16'd32; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0; in_valid = 1'b1; m_ready = 1'b0;
    while (!m_valid && cyc < 100) begin
      in_data = stim[idx];
      @(negedge clk); take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    checks++; if (m_valid !== 1'b1 || idx !== 16) begin failures++; $display("FAIL bp_fill: got m_valid=%b accepted=%0d want 1 16", m_valid, idx); end
    cap_addr = m_addr; cap_data = m_wdata; cap_strb = m_wstrb;
    for (int c = 0; c < 10; c++) begin
      in_data = stim[idx];
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
      checks++;
      if (m_valid !== 1'b1 || m_addr !== cap_addr || m_wdata !== cap_data || m_wstrb !== cap_strb) begin
        failures++; $display("FAIL bp_hold_c%0d: got valid=%b addr=%h strb=%h want valid=1 addr=%h strb=%h", c, m_valid, m_addr, m_wstrb, cap_addr, cap_strb);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    take = in_valid && in_ready;
    @(posedge clk); #1;
    if (take) idx++;
    checks++; if (acc_cnt - ab !== 17) begin failures++; $display("FAIL bp_release_accept: got %0d accepted want 17", acc_cnt - ab); end
    cyc = 0;
    while (busy && cyc < 200) begin
      in_valid = (idx < 32);
      in_data  = stim[idx];
      @(negedge clk); take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    in_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_cnt - wb !== 2) begin failures++; $display("FAIL bp_count: got %0d want 2", wr_cnt - wb); end
    for (int i = 0; i < 2 && i < wr_cnt - wb; i++) begin
      checks++;
      if (wr_addr[wb+i] !== exp_addr[i] || wr_data[wb+i] !== exp_data[i] || wr_strb[wb+i] !== exp_strb[i]) begin
        failures++; $display("FAIL bp_word%0d: got addr=%h data=%h want addr=%h data=%h", i, wr_addr[wb+i], wr_data[wb+i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_boundary;
    int wb; int db; bit to;
    // Address wrap.
    fill_random(32);
    build_model(12'hFFF, 32);
    wb = wr_cnt;
    run_job(12'hFFF, 32, 90, 70, -1, 500, to);
    checks++; if (to || wr_cnt - wb !== 2) begin failures++; $display("FAIL wrap_count: got %0d writes timeout=%b want 2 0", wr_cnt - wb, to); end
    if (wr_cnt - wb >= 2) begin
      checks++; if (wr_addr[wb] !== 12'hFFF || wr_addr[wb+1] !== 12'h000) begin failures++; $display("FAIL wrap_addr: got %h %h want fff 000", wr_addr[wb], wr_addr[wb+1]); end
      checks++; if (wr_data[wb] !== exp_data[0] || wr_data[wb+1] !== exp_data[1]) begin failures++; $display("FAIL wrap_data: got %h want %h", wr_data[wb+1], exp_data[1]); end
    end
    // Empty job.
    wb = wr_cnt; db = done_cnt;
    base_addr = 12'h077; n_samples = 16'd0; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL empty_done: got done=%b busy=%b want 1 0", done, busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_pulse: got done=%b want 0", done); end
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    m_ready = 1'b0;
    checks++; if (wr_cnt !== wb || done_cnt - db !== 1) begin failures++; $display("FAIL empty_nowrite: got writes=%0d dones=%0d want 0 1", wr_cnt - wb, done_cnt - db); end
    // run while busy is ignored.
    fill_random(40);
    build_model(12'h300, 40);
    wb = wr_cnt;
    run_job(12'h300, 40, 80, 80, 3, 800, to);
    checks++; if (to || wr_cnt - wb !== exp_n) begin failures++; $display("FAIL busyrun_count: got %0d writes timeout=%b want %0d", wr_cnt - wb, to, exp_n); end
    for (int i = 0; i < exp_n && i < wr_cnt - wb; i++) begin
      checks++;
      if (wr_addr[wb+i] !== exp_addr[i] || wr_data[wb+i] !== exp_data[i] || wr_strb[wb+i] !== exp_strb[i]) begin
        failures++; $display("FAIL busyrun_word%0d: got addr=%h strb=%h want addr=%h strb=%h", i, wr_addr[wb+i], wr_strb[wb+i], exp_addr[i], exp_strb[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int wb; int ab; int idx; int cyc; bit take; bit to;
    // Reset after 7 samples.
    fill_random(32);
    idx = 0; cyc = 0;
    base_addr = 12'h200; n_samples = 16'd32; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0; in_valid = 1'b1; m_ready = 1'b1;
    while (idx < 7 && cyc < 50) begin
      in_data = stim[idx];
      @(negedge clk); take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_fall: got busy=%b m_valid=%b in_ready=%b want 0 0 0", busy, m_valid, in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    wb = wr_cnt; ab = acc_cnt;
    in_valid = 1'b1; m_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    in_valid = 1'b0; m_ready = 1'b0;
    checks++; if (wr_cnt !== wb || acc_cnt !== ab || busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got writes=%0d accepts=%0d busy=%b want 0 0 0", wr_cnt - wb, acc_cnt - ab, busy); end
    // Reset while a write is pending.
    idx = 0; cyc = 0;
    base_addr = 12'h210; n_samples = 16'd32; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0; in_valid = 1'b1; m_ready = 1'b0;
    while (!m_valid && cyc < 50) begin
      in_data = stim[idx];
      @(negedge clk); take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL rstpend_before: got m_valid=%b want 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || m_wdata !== '0 || m_wstrb !== '0 || m_addr !== '0) begin failures++; $display("FAIL rstpend_clear: got valid=%b addr=%h strb=%h want 0 000 0", m_valid, m_addr, m_wstrb); end
    @(posedge clk); #1;
    rst = 1'b0;
    wb = wr_cnt;
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    m_ready = 1'b0;
    checks++; if (wr_cnt !== wb) begin failures++; $display("FAIL rstpend_discard: got %0d writes want 0", wr_cnt - wb); end
    // A new run works normally.
    fill_random(24);
    build_model(12'h220, 24);
    wb = wr_cnt;
    run_job(12'h220, 24, 80, 80, -1, 500, to);
    checks++; if (to || wr_cnt - wb !== exp_n) begin failures++; $display("FAIL rstnew_count: got %0d writes timeout=%b want %0d", wr_cnt - wb, to, exp_n); end
    for (int i = 0; i < exp_n && i < wr_cnt - wb; i++) begin
      checks++;
      if (wr_addr[wb+i] !== exp_addr[i] || wr_data[wb+i] !== exp_data[i] || wr_strb[wb+i] !== exp_strb[i]) begin
        failures++; $display("FAIL rstnew_word%0d: got addr=%h data=%h want addr=%h data=%h", i, wr_addr[wb+i], wr_data[wb+i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; base_addr = '0; n_samples = '0;
    in_valid = 1'b0; in_data = '0; m_ready = 1'b0;
    test_reset;
    test_full_stream;
    test_saturation;
    test_partial;
    test_random_jobs;
    test_backpressure;
    test_boundary;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xyolo_wr_pack.md
XYOLO_WR_PACK -- requirements
Module: xyolo_wr_pack

Interface
- REQ-001 Parameter DATAPATH_W, default 32: width of one input result word.
- REQ-002 Parameter OUT_W, default 16: width of one stored output sample.
- REQ-003 Parameter MEM_W, default 256: memory word width; PACK = MEM_W/OUT_W lanes, an integer of at least 2.
- REQ-004 Parameter ADDR_W, default 12: memory word address width.
- REQ-005 Port clk  in  1: single clock; all state updates on the rising edge.
- REQ-006 Port rst  in  1: reset, asynchronous and active-high.
- REQ-007 Port run  in  1: single-cycle start pulse.
- REQ-008 Port base_addr  in  ADDR_W: first write address, sampled on an accepted run.
- REQ-009 Port n_samples  in  16: number of samples in the job, sampled on an accepted run.
- REQ-010 Port in_valid  in  1: a result sample is present.
- REQ-011 Port in_data  in  DATAPATH_W: signed result sample.
- REQ-012 Port in_ready  out  1: the sample is accepted this cycle.
- REQ-013 Port m_valid  out  1: a write request is pending.
- REQ-014 Port m_ready  in  1: memory accepts the write request.
- REQ-015 Port m_addr  out  ADDR_W: word address of the write.
- REQ-016 Port m_wdata  out  MEM_W: packed data; lane k occupies bits [k*OUT_W +: OUT_W].
- REQ-017 Port m_wstrb  out  MEM_W/8: byte enables.
- REQ-018 Port busy  out  1: a job is in progress.
- REQ-019 Port done  out  1: single-cycle pulse at job completion.

Function
- REQ-020 The FSM states SHALL be IDLE, RUN, FLUSH and DONE.
  - IDLE -> RUN on run with n_samples != 0.
  - IDLE -> DONE on run with n_samples == 0.
  - RUN -> FLUSH after the last sample is accepted.
  - FLUSH -> DONE when the output register is empty.
  - DONE -> IDLE unconditionally after one cycle.
- REQ-021 run outside IDLE SHALL be ignored, including the captured base_addr and n_samples.
- REQ-022 busy SHALL be 1 in RUN and FLUSH and 0 in IDLE and DONE.
- REQ-023 done SHALL be 1 only in DONE.
- REQ-024 Each accepted sample SHALL be saturated to signed OUT_W, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- REQ-025 The saturated sample SHALL be written into the lane given by a lane counter, starting at lane 0.
- REQ-026 in_ready SHALL equal (state==RUN) && (!m_valid || m_ready).
- REQ-027 A sample is accepted when in_valid && in_ready.
- REQ-028 The output register SHALL be a single entry.
- REQ-029 The output register SHALL be freed in the cycle m_valid && m_ready, and SHALL be reloadable in that same cycle.
- REQ-030 When the accepted sample fills lane PACK-1, the word SHALL load into the output register.
  - Load takes effect on that edge; m_valid=1 the following cycle (one-cycle latency).
  - m_wstrb is all ones.
  - The lane counter returns to 0.
- REQ-031 When the last job sample fills a lane below PACK-1, the partial word SHALL load into the output register on the same edge.
  - m_wstrb is 1 only for the bytes of lanes 0..lane.
  - Unfilled lanes carry zero.
- REQ-032 m_addr SHALL start at base_addr and increment by 1 after each accepted write.
- REQ-033 m_addr SHALL wrap modulo 2^ADDR_W.
- REQ-034 m_valid, m_addr, m_wdata and m_wstrb SHALL hold stable while m_valid && !m_ready.
- REQ-035 An internal sample counter SHALL count accepted samples up to n_samples; no sample is accepted beyond n_samples.

Reset
- REQ-036 On rst, regardless of job state:
  - state = IDLE; lane and sample counters = 0; address = 0.
  - Outputs in_ready, m_valid, busy, done = 0; m_wdata = 0; m_wstrb = 0.
- REQ-037 A pending write SHALL be discarded on rst.
- REQ-038 After rst deasserts, the block SHALL need a new run to start a job.

Verification
- REQ-039 Full-word stream (defaults, base_addr=0x010, n_samples=32, in_valid=1, m_ready=1, in_data=0..31):
  - 2 writes: addr 0x010 then 0x011, m_wstrb all ones.
  - Lane k of word 0 = k.
  - done pulses once, after the second write is accepted.
- REQ-040 Saturation, one word containing in_data = 0x00012345, 0xFFFF0000, 0x00007FFF and 0xFFFF8000:
  - Lanes hold 0x7FFF, 0x8000, 0x7FFF, 0x8000.
- REQ-041 Partial flush (n_samples=20):
  - Second write has m_wstrb=0x000000FF.
  - Lanes 4..15 of the second write = 0.
- REQ-042 Backpressure (m_ready=0 for 10 cycles while the register is full):
  - in_ready=0 throughout; m_addr, m_wdata, m_wstrb unchanged.
  - Exactly one sample is accepted in the cycle m_ready returns.
- REQ-043 Boundary cases:
  - base_addr=0xFFF with 2 words: addresses 0xFFF then 0x000.
  - run with n_samples=0: done one cycle later, no write.
  - run while busy: ignored.
- REQ-044 Reset mid-job (rst asserted after 7 samples): m_valid and busy fall immediately; no write after deassert until a new run.
